// File: rtl/hazard_pkg.sv
// Shared types and helpers for the ID-stage hazard scoreboard.
// Forwarding codes, scoreboard entry layout and the source-match rule.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  function automatic logic src_match(
    input logic       rd_en,
    input logic [4:0] rs,
    input sb_entry_t  s
  );
    return rd_en & (rs != 5'd0) & s.v & (s.rd == rs);
  endfunction

  // A load still in EX cannot forward; that case is a stall.
  function automatic logic [1:0] fwd_sel(
    input logic m_ex,
    input logic ex_ld,
    input logic m_mem,
    input logic m_wb
  );
    if (m_ex & !ex_ld) return FWD_EX;
    else if (m_mem)    return FWD_MEM;
    else if (m_wb)     return FWD_WB;
    else               return FWD_RF;
  endfunction

endpackage

// File: rtl/sb_stage.sv
// One scoreboard entry: async-reset register that holds while en is low.
// Clears to the empty entry on reset.
module sb_stage
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      rstn,
  input  logic      en,
  input  sb_entry_t d,
  output sb_entry_t q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      q <= SB_EMPTY;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: EX/MEM/WB destination scoreboard driving
// load-use stalls, bubbles, operand forwarding and a stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_reada,
  input  logic        id_readb,
  input  logic        id_protect,
  input  logic        id_load,
  input  logic        ex_flush,
  input  logic        mem_busy,
  output logic        stall_id,
  output logic        ex_bubble,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt
);

  sb_entry_t ex_q, mem_q, wb_q, ex_d;
  logic      adv;
  logic      ma_ex, ma_mem, ma_wb;
  logic      mb_ex, mb_mem, mb_wb;
  logic      ldstall;
  logic [15:0] cnt_q;

  assign adv = !mem_busy;

  assign ma_ex  = src_match(id_reada, id_rs1, ex_q);
  assign ma_mem = src_match(id_reada, id_rs1, mem_q);
  assign ma_wb  = src_match(id_reada, id_rs1, wb_q);
  assign mb_ex  = src_match(id_readb, id_rs2, ex_q);
  assign mb_mem = src_match(id_readb, id_rs2, mem_q);
  assign mb_wb  = src_match(id_readb, id_rs2, wb_q);

  assign ldstall = id_valid & !ex_flush & ex_q.ld
                 & (ma_ex | mb_ex);

  assign stall_id  = ldstall | mem_busy;
  assign ex_bubble = (ldstall | ex_flush) & !mem_busy;

  assign fwd_a = fwd_sel(ma_ex, ex_q.ld, ma_mem, ma_wb);
  assign fwd_b = fwd_sel(mb_ex, ex_q.ld, mb_mem, mb_wb);

  always_comb begin
    ex_d = SB_EMPTY;
    if (id_valid & id_protect & (id_rd != 5'd0)
        & !ldstall & !ex_flush) begin
      ex_d.v  = 1'b1;
      ex_d.rd = id_rd;
      ex_d.ld = id_load;
    end
  end

  sb_stage u_ex (
    .clk  (clk),
    .rstn (rstn),
    .en   (adv),
    .d    (ex_d),
    .q    (ex_q)
  );

  sb_stage u_mem (
    .clk  (clk),
    .rstn (rstn),
    .en   (adv),
    .d    (ex_q),
    .q    (mem_q)
  );

  sb_stage u_wb (
    .clk  (clk),
    .rstn (rstn),
    .en   (adv),
    .d    (mem_q),
    .q    (wb_q)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      cnt_q <= '0;
    else if (ldstall & adv & (cnt_q != 16'hFFFF))
      cnt_q <= cnt_q + 16'd1;
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: vector table for steady-state
// hazards plus hand sequences for flush, mem_busy, reset and saturation.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rstn;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_reada, id_readb, id_protect, id_load;
  logic        ex_flush, mem_busy;
  logic        stall_id, ex_bubble;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;

  int nvec;
  int nerr;

  hazard_scoreboard dut (
    .clk        (clk),
    .rstn       (rstn),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rd      (id_rd),
    .id_reada   (id_reada),
    .id_readb   (id_readb),
    .id_protect (id_protect),
    .id_load    (id_load),
    .ex_flush   (ex_flush),
    .mem_busy   (mem_busy),
    .stall_id   (stall_id),
    .ex_bubble  (ex_bubble),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        val;
    logic [4:0]  rs1, rs2, rd;
    logic        ra, rb, pr, ld, fl, bz;
    logic        e_stall, e_bub, chk_fwd;
    logic [1:0]  e_fa, e_fb;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic val,
    input logic [4:0] rs1, rs2, rd,
    input logic ra, rb, pr, ld, fl, bz,
    input logic es, eb, cf,
    input logic [1:0] fa, fb,
    input logic [15:0] cnt
  );
    vec_t x;
    x.val = val; x.rs1 = rs1; x.rs2 = rs2; x.rd = rd;
    x.ra = ra; x.rb = rb; x.pr = pr; x.ld = ld;
    x.fl = fl; x.bz = bz;
    x.e_stall = es; x.e_bub = eb; x.chk_fwd = cf;
    x.e_fa = fa; x.e_fb = fb; x.e_cnt = cnt;
    return x;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic val,
    input logic [4:0] rs1, rs2, rd,
    input logic ra, rb, pr, ld, fl, bz
  );
    id_valid = val; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_reada = ra; id_readb = rb; id_protect = pr; id_load = ld;
    ex_flush = fl; mem_busy = bz;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lw5();
    drive(1, 0, 0, 5, 1, 0, 1, 1, 0, 0);
    tick();
  endtask

  task automatic use5(input logic fl, input logic bz);
    drive(1, 5, 7, 6, 1, 1, 1, 0, fl, bz);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // load-use, then forwarding from MEM
    tbl.push_back(mk(1, 1, 0, 5, 1,0,1,1,0,0, 0,0,1, 0,0, 0));
    tbl.push_back(mk(1, 5, 7, 6, 1,1,1,0,0,0, 1,1,0, 0,0, 0));
    tbl.push_back(mk(1, 5, 7, 6, 1,1,1,0,0,0, 0,0,1, 2,0, 1));
    // ALU result forwarded from EX, MEM, WB
    tbl.push_back(mk(1, 0, 0, 5, 1,0,1,0,0,0, 0,0,1, 0,0, 1));
    tbl.push_back(mk(1, 5, 5, 8, 1,1,1,0,0,0, 0,0,1, 1,1, 1));
    tbl.push_back(mk(1, 0, 0, 5, 1,0,1,0,0,0, 0,0,1, 0,0, 1));
    tbl.push_back(mk(1, 0, 0, 9, 1,0,1,0,0,0, 0,0,1, 0,0, 1));
    tbl.push_back(mk(1, 5, 5, 8, 1,1,1,0,0,0, 0,0,1, 2,2, 1));
    tbl.push_back(mk(1, 5, 5,10, 1,1,1,0,0,0, 0,0,1, 3,3, 1));
    // x0 never tracked
    tbl.push_back(mk(1, 0, 0, 0, 1,0,1,0,0,0, 0,0,1, 0,0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1,0,1,1,0,0, 0,0,1, 0,0, 1));
    tbl.push_back(mk(1, 0, 0,11, 1,1,1,0,0,0, 0,0,1, 0,0, 1));
    // priority EX > MEM > WB
    tbl.push_back(mk(1, 0, 0,12, 1,0,1,0,0,0, 0,0,1, 0,0, 1));
    tbl.push_back(mk(1,12, 0,12, 1,0,1,0,0,0, 0,0,1, 1,0, 1));
    tbl.push_back(mk(1,12,11,13, 1,1,1,0,0,0, 0,0,1, 1,3, 1));
    tbl.push_back(mk(1,12,13, 1, 1,1,1,0,0,0, 0,0,1, 2,1, 1));
    // invalid ID slot: no stall, nothing enters EX
    tbl.push_back(mk(1, 0, 0,14, 1,0,1,1,0,0, 0,0,1, 0,0, 1));
    tbl.push_back(mk(0,14, 0,15, 1,0,1,0,0,0, 0,0,1, 0,0, 1));
    tbl.push_back(mk(1, 0,14, 2, 1,1,1,0,0,0, 0,0,1, 0,2, 1));
    // plain flush kills ID write
    tbl.push_back(mk(1, 2, 0, 3, 1,0,1,0,1,0, 0,1,1, 1,0, 1));
    tbl.push_back(mk(1, 3, 2, 4, 1,1,1,0,0,0, 0,0,1, 0,2, 1));

    // reset state
    #2;
    chk("rst_bub_flush", ex_bubble, 1);
    chk("rst_stall_flush", stall_id, 0);
    drive(1, 5, 5, 5, 1, 1, 1, 1, 0, 1);
    #1;
    chk("rst_stall_busy", stall_id, 1);
    chk("rst_bub_busy", ex_bubble, 0);
    chk("rst_fa", fwd_a, 0);
    chk("rst_fb", fwd_b, 0);
    chk("rst_cnt", stall_cnt, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    rstn = 1'b1;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].val, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
            tbl[i].ra, tbl[i].rb, tbl[i].pr, tbl[i].ld,
            tbl[i].fl, tbl[i].bz);
      #4;
      chk($sformatf("v%0d stall", i), stall_id, tbl[i].e_stall);
      chk($sformatf("v%0d bubble", i), ex_bubble, tbl[i].e_bub);
      chk($sformatf("v%0d cnt", i), stall_cnt, tbl[i].e_cnt);
      if (tbl[i].chk_fwd) begin
        chk($sformatf("v%0d fwd_a", i), fwd_a, tbl[i].e_fa);
        chk($sformatf("v%0d fwd_b", i), fwd_b, tbl[i].e_fb);
      end
      tick();
    end

    // flush beats load-use
    lw5();
    use5(1, 0);
    #4;
    chk("fl_bubble", ex_bubble, 1);
    chk("fl_stall", stall_id, 0);
    tick();
    chk("fl_ex_v", dut.ex_q.v, 0);
    chk("fl_cnt", stall_cnt, 1);

    // mem_busy freezes a pending load-use
    lw5();
    for (int k = 0; k < 3; k++) begin
      use5(0, 1);
      #4;
      chk($sformatf("busy%0d stall", k), stall_id, 1);
      chk($sformatf("busy%0d bubble", k), ex_bubble, 0);
      tick();
      chk($sformatf("busy%0d ex_ld", k), dut.ex_q.ld, 1);
      chk($sformatf("busy%0d ex_rd", k), dut.ex_q.rd, 5);
      chk($sformatf("busy%0d cnt", k), stall_cnt, 1);
    end
    use5(0, 0);
    #4;
    chk("rel_stall", stall_id, 1);
    chk("rel_bubble", ex_bubble, 1);
    tick();
    use5(0, 0);
    #4;
    chk("rel2_stall", stall_id, 0);
    chk("rel2_fa", fwd_a, 2);
    chk("rel2_cnt", stall_cnt, 2);
    tick();

    // reset mid-stall
    lw5();
    use5(0, 0);
    #2;
    chk("pre_rst_stall", stall_id, 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_stall", stall_id, 0);
    chk("mid_rst_bubble", ex_bubble, 0);
    chk("mid_rst_cnt", stall_cnt, 0);
    #1;
    rstn = 1'b1;
    #1;
    chk("post_rst_stall", stall_id, 0);
    chk("post_rst_fa", fwd_a, 0);
    tick();

    // counter saturation
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    lw5();
    use5(0, 0);
    #4;
    chk("sat_stall", stall_id, 1);
    tick();
    chk("sat_cnt1", stall_cnt, 16'hFFFF);
    tick();
    lw5();
    use5(0, 0);
    #4;
    chk("sat_stall2", stall_id, 1);
    tick();
    chk("sat_cnt2", stall_cnt, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
